multiscale_keypoint_finder: RTL and testbench
=============================================

// Module: multiscale_keypoint_finder
// PURPOSE
//  Scans NUM_LAYERS stacked DoG layers of one octave and flags scale-space extrema.
//  - A pixel at interior scale s is a keypoint when it is strictly > all 26 neighbours,
//    or strictly < all 26 neighbours, in the 3x3x3 cube across layers s-1..s+1.
//  - Keypoint coordinates {scale,y,x} are written sequentially into a keypoint BRAM.
//  - Sits after the DoG stage and before descriptor generation.
//  - Generalises single-triple extrema search to any layer count and to rectangular images.
// PARAMETERS
//  BIT_DEPTH      8    width of signed DoG sample
//  WIDTH          64   image width, pixels (>=3)
//  HEIGHT         64   image height, pixels (>=3)
//  NUM_LAYERS     3    DoG layers in stack (>=3); interior scales 1..NUM_LAYERS-2
//  READ_LATENCY   2    DoG BRAM read latency, cycles (1=LOW_LATENCY, 2=HIGH_PERFORMANCE)
//  MAX_KEYPOINTS  256  keypoint BRAM depth
//  CONTRAST_THRESH 4   min |centre| for acceptance (used only with macro)
// PORTS
//  clk             in   1                     system clock
//  rst_in          in   1                     async active-high reset
//  start           in   1                     1-cycle pulse: begin scan (ignored unless IDLE)
//  dog_read_addr   out  clog2(W*H)            shared read address to all DoG BRAMs, addr=y*WIDTH+x
//  dog_data        in   NUM_LAYERS*BIT_DEPTH  layer L occupies [L*BIT_DEPTH +: BIT_DEPTH], signed
//  key_write_addr  out  clog2(MAX_KEYPOINTS)  keypoint BRAM write address
//  key_wea         out  1                     keypoint write strobe
//  keypoint_out    out  SCALE_W+Y_W+X_W       {scale,y,x}, valid with key_wea
//  keypoint_count  out  clog2(MAX_KEYPOINTS)+1  keypoints written this scan
//  overflow        out  1                     sticky: an extremum was dropped, BRAM full
//  busy            out  1                     high from accepted start until done
//  keypoints_done  out  1                     1-cycle pulse at scan end
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; state=IDLE.
//  - Async reset mid-scan aborts immediately; no done pulse.
//  FSM: IDLE -> FETCH -> EVAL -> WRITE -> NEXT -> (FETCH | DONE) -> IDLE
//  IDLE:
//  - On start: clear keypoint_count/overflow/key_write_addr; (x,y)=(1,1); busy=1.
//  FETCH:
//  - Issue the 9 window addresses (dy,dx in -1..1, row-major), one per cycle.
//  - Capture dog_data exactly READ_LATENCY cycles after each issue into window regs [9][NUM_LAYERS].
//  - FETCH lasts 9+READ_LATENCY cycles.
//  EVAL (1 cycle):
//  - Per interior scale s, in parallel: is_max/is_min over 26 signed neighbours.
//  - Equality with any neighbour disqualifies.
//  - Result latched as bitmask flags[NUM_LAYERS-2].
//  WRITE:
//  - Walk flags LSB first; one key_wea pulse per set bit, one cycle each.
//  - On each pulse: keypoint_out={s,y,x}; key_write_addr=count; count then increments.
//  - Zero set bits: WRITE takes 0 cycles.
//  - If count==MAX_KEYPOINTS: no pulse, overflow<=1, flag consumed; scan continues.
//  NEXT:
//  - x++; at x==WIDTH-1 wrap x=1, y++; after (WIDTH-2,HEIGHT-2) go DONE.
//  DONE:
//  - keypoints_done=1 for one cycle; busy=0.
//  - count/overflow held until next start.
//  Scan constraints:
//  - Border pixels (x or y in {0,W-1,H-1}) and layers 0, NUM_LAYERS-1 never tested.
//  - start while busy is ignored.
//  - start in same cycle as keypoints_done is ignored.
//  Latency: per pixel 9+READ_LATENCY+1+(flags written)+1 cycles.
// CONFIGURATION
//  CONTRAST_THRESH_EN
//  - defined: extremum at s also requires |centre| > CONTRAST_THRESH (signed abs, BIT_DEPTH+1 bits).
//  - undefined: no contrast test; CONTRAST_THRESH unused.
// STRUCTURE
//  sift_pkg: X_W/Y_W/SCALE_W width functions, keypoint_t packed struct {scale,y,x}, fsm enum.
//  Sub-module extremum_check:
//  - combinational, one instance per interior scale.
//  - inputs: 27 signed samples; outputs: is_max, is_min.
// TESTING
//  T1: 4x4, 3 layers, all zero except L1(1,1)=10 -> one write {1,1,1} at addr 0; count=1.
//  T2: same, L1(2,2)=-10 -> minimum {1,2,2}; count=1.
//  T3: L1(1,1)=10, L0(0,0)=10 (tie) -> no writes; done pulses; count=0.
//  T4: 5x4, 5 layers, L1(1,1)=9, L3(1,1)=9, L2(1,1)=0 -> writes {1,1,1} then {3,1,1}, addrs 0,1.
//  T5: MAX_KEYPOINTS=2, three isolated maxima -> two writes, overflow=1, count=2.
//  T6: reset pulse mid-FETCH -> outputs 0, no done; new start rescans fully.
//  T7 (CONTRAST_THRESH_EN, thresh=4): L1(1,1)=3 -> no write; =5 -> write.
//  Every test: READ_LATENCY 1 and 2; key_wea count == keypoint_count.

Source files
------------

// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - coordinate widths, keypoint record and FSM encodings for the keypoint finder
package sift_pkg;

  function automatic int x_w(input int width);
    return $clog2(width);
  endfunction

  function automatic int y_w(input int height);
    return $clog2(height);
  endfunction

  function automatic int scale_w(input int num_layers);
    return $clog2(num_layers);
  endfunction

  // Fixed-width record for descriptor stages that collect keypoints across octaves.
  typedef struct packed {
    logic [7:0]  scale;
    logic [15:0] y;
    logic [15:0] x;
  } keypoint_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EVAL  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/multiscale_keypoint_finder_extremum_check.sv
// rtl/multiscale_keypoint_finder_extremum_check.sv - strict max/min test of a 3x3x3 cube centre
module extremum_check
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 8
) (
  input  logic [27*BIT_DEPTH-1:0] cube,
  output logic                    is_max,
  output logic                    is_min
);

  logic signed [BIT_DEPTH-1:0] centre;
  logic signed [BIT_DEPTH-1:0] nb;

  // Cube is layer-major, row-major within a layer, so the centre is sample 13.
  always_comb begin
    centre = cube[13*BIT_DEPTH +: BIT_DEPTH];
    nb     = '0;
    is_max = 1'b1;
    is_min = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i != 13) begin
        nb = cube[i*BIT_DEPTH +: BIT_DEPTH];
        if (nb >= centre) is_max = 1'b0;
        if (nb <= centre) is_min = 1'b0;
      end
    end
  end

endmodule

// File: rtl/multiscale_keypoint_finder.sv
// rtl/multiscale_keypoint_finder.sv - DoG scale-space extremum scanner; CONTRAST_THRESH_EN adds a |centre| gate
module multiscale_keypoint_finder
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH       = 8,
  parameter int WIDTH           = 64,
  parameter int HEIGHT          = 64,
  parameter int NUM_LAYERS      = 3,
  parameter int READ_LATENCY    = 2,
  parameter int MAX_KEYPOINTS   = 256,
  parameter int CONTRAST_THRESH = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst_in,
  input  logic                                                 start,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]                      dog_read_addr,
  input  logic [NUM_LAYERS*BIT_DEPTH-1:0]                      dog_data,
  output logic [$clog2(MAX_KEYPOINTS)-1:0]                     key_write_addr,
  output logic                                                 key_wea,
  output logic [scale_w(NUM_LAYERS)+y_w(HEIGHT)+x_w(WIDTH)-1:0] keypoint_out,
  output logic [$clog2(MAX_KEYPOINTS):0]                       keypoint_count,
  output logic                                                 overflow,
  output logic                                                 busy,
  output logic                                                 keypoints_done
);

  localparam int X_W        = x_w(WIDTH);
  localparam int Y_W        = y_w(HEIGHT);
  localparam int S_W        = scale_w(NUM_LAYERS);
  localparam int ADDR_W     = $clog2(WIDTH*HEIGHT);
  localparam int KEY_AW     = $clog2(MAX_KEYPOINTS);
  localparam int NS         = NUM_LAYERS - 2;
  localparam int LSB_W      = $clog2(NS + 1);
  localparam int FETCH_LAST = 8 + READ_LATENCY;
  localparam int FC_W       = $clog2(FETCH_LAST + 1);

  logic [2:0]        state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [NS-1:0]     flags_q, flags_d, flags_eval;
  logic [KEY_AW:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic signed [BIT_DEPTH-1:0] win_q [9][NUM_LAYERS];
  logic signed [BIT_DEPTH-1:0] win_d [9][NUM_LAYERS];
  logic [LSB_W-1:0]  lsb_idx;
  logic [S_W-1:0]    wr_scale;
  logic              count_full;
  int                tap;

  for (genvar s = 1; s <= NS; s++) begin : g_scale
    logic [27*BIT_DEPTH-1:0] cube;
    logic                    is_max;
    logic                    is_min;
    for (genvar j = 0; j < 3; j++) begin : g_layer
      for (genvar k = 0; k < 9; k++) begin : g_tap
        assign cube[(j*9+k)*BIT_DEPTH +: BIT_DEPTH] = win_q[k][s-1+j];
      end
    end
    extremum_check #(.BIT_DEPTH(BIT_DEPTH)) u_check (
      .cube   (cube),
      .is_max (is_max),
      .is_min (is_min)
    );
`ifdef CONTRAST_THRESH_EN
    logic [BIT_DEPTH:0] centre_ext;
    logic [BIT_DEPTH:0] centre_abs;
    assign centre_ext = {win_q[4][s][BIT_DEPTH-1], win_q[4][s]};
    assign centre_abs = centre_ext[BIT_DEPTH] ? ((BIT_DEPTH+1)'(0) - centre_ext) : centre_ext;
    assign flags_eval[s-1] = (is_max | is_min) && (centre_abs > (BIT_DEPTH+1)'(CONTRAST_THRESH));
`else
    assign flags_eval[s-1] = is_max | is_min;
`endif
  end

  always_comb begin
    lsb_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (flags_q[i]) lsb_idx = LSB_W'(i);
    end
  end

  assign wr_scale   = S_W'(lsb_idx) + S_W'(1);
  assign count_full = (count_q == (KEY_AW+1)'(MAX_KEYPOINTS));
  assign tap        = int'(fc_q) - READ_LATENCY;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    fc_d       = fc_q;
    flags_d    = flags_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    win_d      = win_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          x_d        = X_W'(1);
          y_d        = Y_W'(1);
          fc_d       = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      ST_FETCH: begin
        // Data for the tap issued READ_LATENCY cycles ago is on dog_data now.
        if (tap >= 0 && tap < 9) begin
          for (int l = 0; l < NUM_LAYERS; l++) begin
            win_d[tap[3:0]][l] = dog_data[l*BIT_DEPTH +: BIT_DEPTH];
          end
        end
        if (fc_q == FC_W'(FETCH_LAST)) begin
          fc_d    = '0;
          state_d = ST_EVAL;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
      ST_EVAL: begin
        flags_d = flags_eval;
        state_d = (flags_eval == '0) ? ST_NEXT : ST_WRITE;
      end
      ST_WRITE: begin
        flags_d[lsb_idx] = 1'b0;
        if (count_full) overflow_d = 1'b1;
        else            count_d    = count_q + 1'b1;
        if (flags_d == '0) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (x_q == X_W'(WIDTH - 2)) begin
          x_d = X_W'(1);
          if (y_q == Y_W'(HEIGHT - 2)) begin
            state_d = ST_DONE;
          end else begin
            y_d     = y_q + 1'b1;
            state_d = ST_FETCH;
          end
        end else begin
          x_d     = x_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      fc_q       <= '0;
      flags_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        for (int l = 0; l < NUM_LAYERS; l++) begin
          win_q[k][l] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fc_q       <= fc_d;
      flags_q    <= flags_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      win_q      <= win_d;
    end
  end

  always_comb begin
    dog_read_addr = '0;
    if (state_q == ST_FETCH && fc_q < FC_W'(9)) begin
      dog_read_addr = ADDR_W'((int'(y_q) + int'(fc_q) / 3 - 1) * WIDTH + int'(x_q) + int'(fc_q) % 3 - 1);
    end
  end

  assign key_wea        = (state_q == ST_WRITE) && !count_full;
  assign keypoint_out   = key_wea ? {wr_scale, y_q, x_q} : '0;
  assign key_write_addr = count_q[KEY_AW-1:0];
  assign keypoint_count = count_q;
  assign overflow       = overflow_q;
  assign busy           = (state_q == ST_FETCH) || (state_q == ST_EVAL) ||
                          (state_q == ST_WRITE) || (state_q == ST_NEXT);
  assign keypoints_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_multiscale_keypoint_finder.sv
// tb/tb_multiscale_keypoint_finder.sv - directed scans of 4x4x3 and 5x4x5 stacks at read latency 1 and 2
module tb_multiscale_keypoint_finder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_c [2];
  logic signed [7:0] img [2][5][20];

  always #5 clk = ~clk;

  wire [31:0] nwr_w   [4];
  wire [31:0] ndone_w [4];
  wire [31:0] nbusy_w [4];
  wire [31:0] cnt_w   [4];
  wire        ovf_w   [4];
  wire        busy_w  [4];
  wire        dn_w    [4];
  wire        anyout_w[4];
  wire [31:0] log_w   [4][16];

  int checks = 0;
  int errors = 0;
  int base_wr   [4];
  int base_done [4];
  int base_busy [4];

  // Instances 0,1: 4x4, 3 layers, 256 keys. Instances 2,3: 5x4, 5 layers, 2 keys. Odd = latency 2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CFG = g / 2;
    localparam int RL  = (g % 2) + 1;
    localparam int W   = (CFG == 0) ? 4 : 5;
    localparam int NL  = (CFG == 0) ? 3 : 5;
    localparam int MK  = (CFG == 0) ? 256 : 2;
    localparam int AW  = $clog2(W * 4);
    localparam int KW  = $clog2(MK);
    localparam int XW  = $clog2(W);
    localparam int YW  = 2;
    localparam int SW  = $clog2(NL);

    logic [AW-1:0]       rd_addr;
    logic [NL*8-1:0]     p1, p2, dog;
    logic [KW-1:0]       kwa;
    logic                kwe;
    logic [SW+YW+XW-1:0] kpo;
    logic [KW:0]         kcnt;
    logic                ovf, bsy, dn;
    int                  nwr = 0;
    int                  ndone = 0;
    int                  nbusy = 0;
    logic [31:0]         lg [16];

    multiscale_keypoint_finder #(
      .BIT_DEPTH(8), .WIDTH(W), .HEIGHT(4), .NUM_LAYERS(NL),
      .READ_LATENCY(RL), .MAX_KEYPOINTS(MK), .CONTRAST_THRESH(4)
    ) dut (
      .clk            (clk),
      .rst_in         (rst),
      .start          (start_c[CFG]),
      .dog_read_addr  (rd_addr),
      .dog_data       (dog),
      .key_write_addr (kwa),
      .key_wea        (kwe),
      .keypoint_out   (kpo),
      .keypoint_count (kcnt),
      .overflow       (ovf),
      .busy           (bsy),
      .keypoints_done (dn)
    );

    always @(posedge clk) begin
      for (int l = 0; l < NL; l++) p1[l*8 +: 8] <= img[CFG][l][rd_addr];
      p2 <= p1;
    end
    assign dog = (RL == 1) ? p1 : p2;

    always @(negedge clk) begin
      if (!rst) begin
        if (kwe) begin
          lg[nwr % 16] <= {8'(kwa), 8'(kpo[SW+YW+XW-1 -: SW]), 8'(kpo[YW+XW-1 -: YW]), 8'(kpo[XW-1:0])};
          nwr <= nwr + 1;
        end
        if (dn)  ndone <= ndone + 1;
        if (bsy) nbusy <= nbusy + 1;
      end
    end

    assign nwr_w[g]    = nwr;
    assign ndone_w[g]  = ndone;
    assign nbusy_w[g]  = nbusy;
    assign cnt_w[g]    = 32'(kcnt);
    assign ovf_w[g]    = ovf;
    assign busy_w[g]   = bsy;
    assign dn_w[g]     = dn;
    assign anyout_w[g] = |{rd_addr, kwa, kwe, kpo, kcnt, ovf, bsy, dn};
    for (genvar i = 0; i < 16; i++) begin : g_log
      assign log_w[g][i] = lg[i];
    end
  end

  task automatic clear_img();
    for (int c = 0; c < 2; c++)
      for (int l = 0; l < 5; l++)
        for (int a = 0; a < 20; a++) img[c][l][a] = 8'sd0;
  endtask

  task automatic start_scan(input int c);
    for (int g = 0; g < 4; g++) begin
      base_wr[g]   = int'(nwr_w[g]);
      base_done[g] = int'(ndone_w[g]);
      base_busy[g] = int'(nbusy_w[g]);
    end
    @(negedge clk);
    start_c[c] = 1'b1;
    @(negedge clk);
    start_c[c] = 1'b0;
  endtask

  // With poke set, start is re-asserted in the very cycle the latency-1 instance signals done.
  task automatic wait_done(input int c, input bit poke);
    int i;
    i = 0;
    while (i < 3000 && !(int'(ndone_w[2*c]) != base_done[2*c] && int'(ndone_w[2*c+1]) != base_done[2*c+1])) begin
      @(negedge clk);
      start_c[c] = poke & dn_w[2*c];
      i++;
    end
    start_c[c] = 1'b0;
    checks++;
    if (i >= 3000) begin
      errors++;
      $display("FAIL done_timeout cfg%0d: waited %0d cycles, required a done pulse", c, i);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (anyout_w[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs g%0d: got %b required 0", g, anyout_w[g]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Shared result checks for a finished scan: writes, count, overflow, done pulses, busy cycles, logged keys.
  task automatic test_scan_result(input string name, input int c, input int nwr_exp, input int cnt_exp,
                                  input bit ovf_exp, input int nflags, input logic [31:0] k0, input logic [31:0] k1);
    for (int g = 2*c; g < 2*c + 2; g++) begin
      int dw, dd, db, be;
      dw = int'(nwr_w[g]) - base_wr[g];
      dd = int'(ndone_w[g]) - base_done[g];
      db = int'(nbusy_w[g]) - base_busy[g];
      be = ((c == 0) ? 4 : 6) * (11 + (g % 2) + 1) + nflags;
      checks++;
      if (dw !== nwr_exp) begin errors++; $display("FAIL %s_writes g%0d: got %0d required %0d", name, g, dw, nwr_exp); end
      checks++;
      if (int'(cnt_w[g]) !== cnt_exp) begin errors++; $display("FAIL %s_count g%0d: got %0d required %0d", name, g, cnt_w[g], cnt_exp); end
      checks++;
      if (ovf_w[g] !== ovf_exp) begin errors++; $display("FAIL %s_overflow g%0d: got %b required %b", name, g, ovf_w[g], ovf_exp); end
      checks++;
      if (dd !== 1) begin errors++; $display("FAIL %s_done g%0d: got %0d pulses required 1", name, g, dd); end
      checks++;
      if (db !== be || busy_w[g] !== 1'b0) begin
        errors++; $display("FAIL %s_busy g%0d: got %0d cycles busy_now=%b required %0d and 0", name, g, db, busy_w[g], be);
      end
      if (nwr_exp > 0) begin
        checks++;
        if (log_w[g][base_wr[g] % 16] !== k0) begin errors++; $display("FAIL %s_key0 g%0d: got %h required %h", name, g, log_w[g][base_wr[g] % 16], k0); end
      end
      if (nwr_exp > 1) begin
        checks++;
        if (log_w[g][(base_wr[g] + 1) % 16] !== k1) begin errors++; $display("FAIL %s_key1 g%0d: got %h required %h", name, g, log_w[g][(base_wr[g] + 1) % 16], k1); end
      end
    end
  endtask

  task automatic test_single_max();
    clear_img();
    img[0][1][5] = 8'sd10;
    start_scan(0);
    repeat (20) @(negedge clk);
    start_c[0] = 1'b1;
    @(negedge clk);
    start_c[0] = 1'b0;
    wait_done(0, 1'b1);
    test_scan_result("max", 0, 1, 1, 1'b0, 1, 32'h00_01_01_01, 32'h0);
  endtask

  task automatic test_single_min();
    clear_img();
    img[0][1][10] = -8'sd10;
    start_scan(0);
    wait_done(0, 1'b0);
    test_scan_result("min", 0, 1, 1, 1'b0, 1, 32'h00_01_02_02, 32'h0);
  endtask

  task automatic test_tie();
    clear_img();
    img[0][1][5] = 8'sd10;
    img[0][0][0] = 8'sd10;
    start_scan(0);
    wait_done(0, 1'b0);
    test_scan_result("tie", 0, 0, 0, 1'b0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_two_scales();
    clear_img();
    img[1][1][6] = 8'sd9;
    img[1][3][6] = 8'sd9;
    start_scan(1);
    wait_done(1, 1'b0);
    test_scan_result("scales", 1, 2, 2, 1'b0, 2, 32'h00_01_01_01, 32'h01_03_01_01);
  endtask

  task automatic test_overflow();
    clear_img();
    img[1][1][6]  = 8'sd9;
    img[1][3][6]  = 8'sd9;
    img[1][2][13] = 8'sd9;
    start_scan(1);
    wait_done(1, 1'b0);
    test_scan_result("ovf", 1, 2, 2, 1'b1, 3, 32'h00_01_01_01, 32'h01_03_01_01);
  endtask

  task automatic test_reset_mid_fetch();
    int d0, d1;
    clear_img();
    img[0][1][5] = 8'sd10;
    start_scan(0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (anyout_w[g] !== 1'b0) begin errors++; $display("FAIL abort_outputs g%0d: got %b required 0", g, anyout_w[g]); end
    end
    rst = 1'b0;
    d0 = int'(ndone_w[0]);
    d1 = int'(ndone_w[1]);
    repeat (100) @(negedge clk);
    checks++;
    if (int'(ndone_w[0]) !== d0 || int'(ndone_w[1]) !== d1 || busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got done deltas %0d/%0d busy %b/%b required 0/0 and 0/0",
                         int'(ndone_w[0]) - d0, int'(ndone_w[1]) - d1, busy_w[0], busy_w[1]);
    end
    start_scan(0);
    wait_done(0, 1'b0);
    test_scan_result("rescan", 0, 1, 1, 1'b0, 1, 32'h00_01_01_01, 32'h0);
  endtask

`ifdef CONTRAST_THRESH_EN
  task automatic test_contrast();
    clear_img();
    img[0][1][5] = 8'sd3;
    start_scan(0);
    wait_done(0, 1'b0);
    test_scan_result("weak", 0, 0, 0, 1'b0, 0, 32'h0, 32'h0);
    img[0][1][5] = 8'sd5;
    start_scan(0);
    wait_done(0, 1'b0);
    test_scan_result("strong", 0, 1, 1, 1'b0, 1, 32'h00_01_01_01, 32'h0);
  endtask
`endif

  initial begin
    start_c[0] = 1'b0;
    start_c[1] = 1'b0;
    clear_img();
    test_reset();
    test_single_max();
    test_single_min();
    test_tie();
    test_two_scales();
    test_overflow();
    test_reset_mid_fetch();
`ifdef CONTRAST_THRESH_EN
    test_contrast();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
